// File: rtl/vsetvl_pkg.sv
// rtl/vsetvl_pkg.sv - shared encodings and constants for the vsetvl unit.
// Optional build macro: VSETVL_FRACTIONAL_LMUL_EN (consumed by vsetvl_vlmax).
package vsetvl_pkg;

  typedef enum logic [1:0] {
    OP_VSETVLI  = 2'd0,
    OP_VSETIVLI = 2'd1,
    OP_VSETVL   = 2'd2,
    OP_RSVD     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_COMPUTE = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  localparam int VLMUL_LSB = 0;
  localparam int VLMUL_MSB = 2;
  localparam int VSEW_LSB  = 3;
  localparam int VSEW_MSB  = 5;
  localparam int VTA_BIT   = 6;
  localparam int VMA_BIT   = 7;

  localparam int VLEN_DEFAULT = 256;

  // Width of the e8/m1 element count VLEN/8 for a given VLEN.
  function automatic int vlmax_bits_f(input int vlen);
    return $clog2(vlen / 8) + 1;
  endfunction

  localparam int VLMAX_BITS = vlmax_bits_f(VLEN_DEFAULT);

endpackage

// File: rtl/vsetvl_vlmax.sv
// rtl/vsetvl_vlmax.sv - combinational vsew/vlmul to {VLMAX, vill} calculator.
// Optional build macro: VSETVL_FRACTIONAL_LMUL_EN enables vlmul 5/6/7.
module vsetvl_vlmax
  import vsetvl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int VLEN  = 256,
  parameter int ELEN  = 32
) (
  input  logic [2:0]       i_vsew,
  input  logic [2:0]       i_vlmul,
  output logic [WIDTH-1:0] o_vlmax,
  output logic             o_vill
);

  localparam int BASE_W = vlmax_bits_f(VLEN);
  localparam logic [BASE_W-1:0] VLEN_E8 = BASE_W'(VLEN / 8);
  localparam logic [10:0] ELEN_W = 11'(ELEN);

  logic [BASE_W-1:0] base;
  logic [10:0]       sew_bits;
`ifdef VSETVL_FRACTIONAL_LMUL_EN
  logic [2:0]        frac_sh;
`endif

  always_comb begin
    // base = VLEN >> (3 + vsew), the m1 element count
    base     = VLEN_E8 >> i_vsew;
    sew_bits = 11'd8 << i_vsew;
    o_vill   = i_vsew[2] | (sew_bits > ELEN_W) | (i_vlmul == 3'd4);
    o_vlmax  = WIDTH'(base) << i_vlmul[1:0];
`ifdef VSETVL_FRACTIONAL_LMUL_EN
    // 8 - vlmul, i.e. log2 of the LMUL divisor for vlmul 5/6/7
    frac_sh = 3'd0 - i_vlmul;
    if (i_vlmul[2]) begin
      o_vlmax = WIDTH'(base) >> frac_sh;
      o_vill  = o_vill | (sew_bits > (ELEN_W >> frac_sh));
    end
`else
    o_vill = o_vill | i_vlmul[2];
`endif
  end

endmodule

// File: rtl/vsetvl_unit.sv
// rtl/vsetvl_unit.sv - multi-cycle vsetvli/vsetivli/vsetvl execution stage feeding the vector CSRs.
// Optional build macro: VSETVL_FRACTIONAL_LMUL_EN (fractional LMUL support).
module vsetvl_unit
  import vsetvl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int VLEN  = 256,
  parameter int ELEN  = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_op,
  input  logic [7:0]       i_vtype_imm,
  input  logic [WIDTH-1:0] i_rs2,
  input  logic [WIDTH-1:0] i_rs1,
  input  logic [4:0]       i_uimm,
  input  logic             i_rs1_is_x0,
  input  logic             i_rd_is_x0,
  input  logic [WIDTH-1:0] i_cur_vl,
  output logic             o_update_vl,
  output logic [WIDTH-1:0] o_vl,
  output logic [7:0]       o_vtype,
  output logic             o_vill,
  output logic             o_done,
  output logic [WIDTH-1:0] o_rd_data
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [7:0]       vtype_imm_q, vtype_imm_d;
  logic [7:0]       rs2_lo_q, rs2_lo_d;
  logic             rs2_hi_nz_q, rs2_hi_nz_d;
  logic [WIDTH-1:0] rs1_q, rs1_d;
  logic [4:0]       uimm_q, uimm_d;
  logic             rs1_x0_q, rs1_x0_d;
  logic             rd_x0_q, rd_x0_d;
  logic [WIDTH-1:0] cur_vl_q, cur_vl_d;
  logic [7:0]       vtype_q, vtype_d;
  logic             bad_hi_q, bad_hi_d;
  logic [WIDTH-1:0] avl_q, avl_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] vl_q, vl_d;
  logic [7:0]       vtype_out_q, vtype_out_d;
  logic             vill_out_q, vill_out_d;

  logic [WIDTH-1:0] vlmax;
  logic             vlmax_vill;
  logic             vill_all;
  logic [7:0]       vtype_src;

  vsetvl_vlmax #(
    .WIDTH (WIDTH),
    .VLEN  (VLEN),
    .ELEN  (ELEN)
  ) u_vlmax (
    .i_vsew  (vtype_q[VSEW_MSB:VSEW_LSB]),
    .i_vlmul (vtype_q[VLMUL_MSB:VLMUL_LSB]),
    .o_vlmax (vlmax),
    .o_vill  (vlmax_vill)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    vtype_imm_d = vtype_imm_q;
    rs2_lo_d    = rs2_lo_q;
    rs2_hi_nz_d = rs2_hi_nz_q;
    rs1_d       = rs1_q;
    uimm_d      = uimm_q;
    rs1_x0_d    = rs1_x0_q;
    rd_x0_d     = rd_x0_q;
    cur_vl_d    = cur_vl_q;
    vtype_d     = vtype_q;
    bad_hi_d    = bad_hi_q;
    avl_d       = avl_q;
    done_d      = 1'b0;
    vl_d        = vl_q;
    vtype_out_d = vtype_out_q;
    vill_out_d  = vill_out_q;
    // op 2 and reserved op 3 both take vtype from rs2
    vtype_src   = op_q[1] ? rs2_lo_q : vtype_imm_q;
    vill_all    = vlmax_vill | bad_hi_q;

    unique case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          op_d        = op_e'(i_op);
          vtype_imm_d = i_vtype_imm;
          rs2_lo_d    = i_rs2[7:0];
          rs2_hi_nz_d = |i_rs2[WIDTH-1:8];
          rs1_d       = i_rs1;
          uimm_d      = i_uimm;
          rs1_x0_d    = i_rs1_is_x0;
          rd_x0_d     = i_rd_is_x0;
          cur_vl_d    = i_cur_vl;
          state_d     = ST_LATCH;
        end
      end
      ST_LATCH: begin
        vtype_d  = {vtype_src[VMA_BIT], vtype_src[VTA_BIT],
                    vtype_src[VSEW_MSB:VSEW_LSB], vtype_src[VLMUL_MSB:VLMUL_LSB]};
        bad_hi_d = op_q[1] & rs2_hi_nz_q;
        if (op_q == OP_VSETIVLI) begin
          avl_d = {{(WIDTH-5){1'b0}}, uimm_q};
        end else if (!rs1_x0_q) begin
          avl_d = rs1_q;
        end else if (!rd_x0_q) begin
          avl_d = '1;
        end else begin
          avl_d = cur_vl_q;
        end
        state_d = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        // min() also covers keep-vl mode clamping to VLMAX
        if (vill_all) begin
          vl_d        = '0;
          vtype_out_d = 8'h00;
        end else begin
          vl_d        = (avl_q < vlmax) ? avl_q : vlmax;
          vtype_out_d = vtype_q;
        end
        vill_out_d = vill_all;
        done_d     = 1'b1;
        state_d    = ST_COMMIT;
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_VSETVLI;
      vtype_imm_q <= 8'h00;
      rs2_lo_q    <= 8'h00;
      rs2_hi_nz_q <= 1'b0;
      rs1_q       <= '0;
      uimm_q      <= 5'd0;
      rs1_x0_q    <= 1'b0;
      rd_x0_q     <= 1'b0;
      cur_vl_q    <= '0;
      vtype_q     <= 8'h00;
      bad_hi_q    <= 1'b0;
      avl_q       <= '0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      vl_q        <= '0;
      vtype_out_q <= 8'h00;
      vill_out_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      vtype_imm_q <= vtype_imm_d;
      rs2_lo_q    <= rs2_lo_d;
      rs2_hi_nz_q <= rs2_hi_nz_d;
      rs1_q       <= rs1_d;
      uimm_q      <= uimm_d;
      rs1_x0_q    <= rs1_x0_d;
      rd_x0_q     <= rd_x0_d;
      cur_vl_q    <= cur_vl_d;
      vtype_q     <= vtype_d;
      bad_hi_q    <= bad_hi_d;
      avl_q       <= avl_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      vl_q        <= vl_d;
      vtype_out_q <= vtype_out_d;
      vill_out_q  <= vill_out_d;
    end
  end

  assign o_ready     = ready_q;
  assign o_done      = done_q;
  assign o_update_vl = done_q;
  assign o_vl        = vl_q;
  assign o_rd_data   = vl_q;
  assign o_vtype     = vtype_out_q;
  assign o_vill      = vill_out_q;

endmodule

// File: tb/tb_vsetvl_unit.sv
// tb/tb_vsetvl_unit.sv - table-driven self-checking bench for vsetvl_unit.
// Expectations for fractional vtypes follow VSETVL_FRACTIONAL_LMUL_EN.
module tb_vsetvl_unit;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_op;
  logic [7:0]  i_vtype_imm;
  logic [31:0] i_rs2;
  logic [31:0] i_rs1;
  logic [4:0]  i_uimm;
  logic        i_rs1_is_x0;
  logic        i_rd_is_x0;
  logic [31:0] i_cur_vl;
  logic        o_update_vl;
  logic [31:0] o_vl;
  logic [7:0]  o_vtype;
  logic        o_vill;
  logic        o_done;
  logic [31:0] o_rd_data;

  int checks = 0;
  int failures = 0;

  vsetvl_unit #(.WIDTH(32), .VLEN(256), .ELEN(32)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_op        (i_op),
    .i_vtype_imm (i_vtype_imm),
    .i_rs2       (i_rs2),
    .i_rs1       (i_rs1),
    .i_uimm      (i_uimm),
    .i_rs1_is_x0 (i_rs1_is_x0),
    .i_rd_is_x0  (i_rd_is_x0),
    .i_cur_vl    (i_cur_vl),
    .o_update_vl (o_update_vl),
    .o_vl        (o_vl),
    .o_vtype     (o_vtype),
    .o_vill      (o_vill),
    .o_done      (o_done),
    .o_rd_data   (o_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  imm;
    logic [31:0] rs2;
    logic [31:0] rs1;
    logic [4:0]  uimm;
    logic        rs1x0;
    logic        rdx0;
    logic [31:0] cur;
    logic [31:0] e_vl;
    logic [7:0]  e_vtype;
    logic        e_vill;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [1:0] op, input logic [7:0] imm,
                              input logic [31:0] rs2, input logic [31:0] rs1,
                              input logic [4:0] uimm, input logic rs1x0, input logic rdx0,
                              input logic [31:0] cur, input logic [31:0] e_vl,
                              input logic [7:0] e_vtype, input logic e_vill);
    vec_t v;
    v.op = op; v.imm = imm; v.rs2 = rs2; v.rs1 = rs1; v.uimm = uimm;
    v.rs1x0 = rs1x0; v.rdx0 = rdx0; v.cur = cur;
    v.e_vl = e_vl; v.e_vtype = e_vtype; v.e_vill = e_vill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_op = 2'd0; i_vtype_imm = 8'h00; i_rs2 = 32'h0; i_rs1 = 32'h0;
    i_uimm = 5'd0; i_rs1_is_x0 = 1'b0; i_rd_is_x0 = 1'b0; i_cur_vl = 32'h0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    i_op = v.op; i_vtype_imm = v.imm; i_rs2 = v.rs2; i_rs1 = v.rs1; i_uimm = v.uimm;
    i_rs1_is_x0 = v.rs1x0; i_rd_is_x0 = v.rdx0; i_cur_vl = v.cur; i_valid = 1'b1;
    chk($sformatf("v%0d_ready_idle", idx), 32'(o_ready), 32'd1);
    @(posedge clk); #1;
    // garble the request and keep i_valid high while busy
    i_op = 2'($urandom); i_vtype_imm = 8'($urandom); i_rs2 = $urandom; i_rs1 = $urandom;
    i_uimm = 5'($urandom); i_rs1_is_x0 = 1'($urandom); i_rd_is_x0 = 1'($urandom);
    i_cur_vl = $urandom;
    lat = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 3) chk($sformatf("v%0d_ready_busy_c%0d", idx, k), 32'(o_ready), 32'd0);
      if (o_done === 1'b1) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    chk($sformatf("v%0d_latency", idx), lat, 32'd3);
    chk($sformatf("v%0d_update", idx), 32'(o_update_vl), 32'd1);
    chk($sformatf("v%0d_vl", idx), o_vl, v.e_vl);
    chk($sformatf("v%0d_rd", idx), o_rd_data, v.e_vl);
    chk($sformatf("v%0d_vtype", idx), 32'(o_vtype), 32'(v.e_vtype));
    chk($sformatf("v%0d_vill", idx), 32'(o_vill), 32'(v.e_vill));
    @(posedge clk); #1;
    chk($sformatf("v%0d_done_pulse", idx), 32'(o_done), 32'd0);
    chk($sformatf("v%0d_ready_again", idx), 32'(o_ready), 32'd1);
    chk($sformatf("v%0d_vl_hold", idx), o_vl, v.e_vl);
  endtask

  initial begin
    int strobes;
    idle_inputs();
    rst_n = 1'b0;

    // op, imm, rs2, rs1, uimm, rs1x0, rdx0, cur, exp vl, exp vtype, exp vill
    tbl.push_back(mk(2'd0, 8'h10, 32'h0, 32'd20, 5'd0, 0, 0, 32'd0, 32'd8, 8'h10, 0));
    tbl.push_back(mk(2'd0, 8'h01, 32'h0, 32'd5, 5'd0, 0, 0, 32'd0, 32'd5, 8'h01, 0));
    tbl.push_back(mk(2'd0, 8'h0A, 32'h0, 32'd0, 5'd0, 1, 0, 32'd0, 32'd64, 8'h0A, 0));
    tbl.push_back(mk(2'd0, 8'h0A, 32'h0, 32'd0, 5'd0, 1, 1, 32'd100, 32'd64, 8'h0A, 0));
    tbl.push_back(mk(2'd2, 8'h00, 32'h18, 32'd10, 5'd0, 0, 0, 32'd0, 32'd0, 8'h00, 1));
    tbl.push_back(mk(2'd2, 8'h00, 32'h1_0000, 32'd10, 5'd0, 0, 0, 32'd0, 32'd0, 8'h00, 1));
`ifdef VSETVL_FRACTIONAL_LMUL_EN
    tbl.push_back(mk(2'd0, 8'h07, 32'h0, 32'd100, 5'd0, 0, 0, 32'd0, 32'd16, 8'h07, 0));
    tbl.push_back(mk(2'd0, 8'h06, 32'h0, 32'd100, 5'd0, 0, 0, 32'd0, 32'd8, 8'h06, 0));
`else
    tbl.push_back(mk(2'd0, 8'h07, 32'h0, 32'd100, 5'd0, 0, 0, 32'd0, 32'd0, 8'h00, 1));
    tbl.push_back(mk(2'd0, 8'h06, 32'h0, 32'd100, 5'd0, 0, 0, 32'd0, 32'd0, 8'h00, 1));
`endif
    tbl.push_back(mk(2'd0, 8'h17, 32'h0, 32'd100, 5'd0, 0, 0, 32'd0, 32'd0, 8'h00, 1));
    tbl.push_back(mk(2'd1, 8'hC0, 32'h0, 32'd999, 5'd31, 0, 0, 32'd0, 32'd31, 8'hC0, 0));
    tbl.push_back(mk(2'd1, 8'h08, 32'h0, 32'd999, 5'd31, 1, 0, 32'd0, 32'd16, 8'h08, 0));
    tbl.push_back(mk(2'd2, 8'h00, 32'h13, 32'd1000, 5'd0, 0, 0, 32'd0, 32'd64, 8'h13, 0));
    tbl.push_back(mk(2'd0, 8'h04, 32'h0, 32'd10, 5'd0, 0, 0, 32'd0, 32'd0, 8'h00, 1));
    tbl.push_back(mk(2'd0, 8'h20, 32'h0, 32'd10, 5'd0, 0, 0, 32'd0, 32'd0, 8'h00, 1));
    tbl.push_back(mk(2'd3, 8'h03, 32'h09, 32'd40, 5'd0, 0, 0, 32'd0, 32'd32, 8'h09, 0));
    tbl.push_back(mk(2'd0, 8'h10, 32'h0, 32'd0, 5'd0, 1, 1, 32'd5, 32'd5, 8'h10, 0));
    tbl.push_back(mk(2'd0, 8'h10, 32'h0, 32'hFFFF_FFFF, 5'd0, 0, 0, 32'd0, 32'd8, 8'h10, 0));
    tbl.push_back(mk(2'd0, 8'h10, 32'h0, 32'd0, 5'd0, 0, 0, 32'd0, 32'd0, 8'h10, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_update", 32'(o_update_vl), 32'd0);
    chk("rst_vl", o_vl, 32'd0);
    chk("rst_rd", o_rd_data, 32'd0);
    chk("rst_vtype", 32'(o_vtype), 32'd0);
    chk("rst_vill", 32'(o_vill), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

    // reset while the request sits in COMPUTE
    @(negedge clk);
    i_op = 2'd0; i_vtype_imm = 8'h10; i_rs1 = 32'd20; i_rs1_is_x0 = 1'b0; i_rd_is_x0 = 1'b0;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(o_ready), 32'd1);
    chk("midrst_vill", 32'(o_vill), 32'd1);
    chk("midrst_vl", o_vl, 32'd0);
    chk("midrst_update", 32'(o_update_vl), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (o_update_vl === 1'b1) strobes++;
    end
    chk("midrst_no_strobe", strobes, 32'd0);
    run_vec(tbl[1], 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
